// File: rtl/f_pc_if.sv
// Fetch-stage control inputs and F/D-register outputs of the PC generator.
// The master side is the PC unit; the slave side is whoever drives control and consumes the fetch.
interface f_pc_if;
    logic        en;
    logic        req;
    logic        eret;
    logic [31:0] epc;
    logic        d_is_branch;
    logic        d_br_taken;
    logic [31:0] d_br_target;
    logic [31:0] f_pc;
    logic [31:0] i_addr;
    logic        i_rd_en;
    logic        f_bd;
    logic [4:0]  f_exccode;
    logic [31:0] fetch_cnt;

    modport master (
        input  en, req, eret, epc, d_is_branch, d_br_taken, d_br_target,
        output f_pc, i_addr, i_rd_en, f_bd, f_exccode, fetch_cnt
    );

    modport slave (
        output en, req, eret, epc, d_is_branch, d_br_taken, d_br_target,
        input  f_pc, i_addr, i_rd_en, f_bd, f_exccode, fetch_cnt
    );
endinterface

// File: rtl/f_pc_unit.sv
// Fetch PC generator: picks vector / epc / branch target / pending target / pc+4 each cycle.
// Latency: redirects land one cycle after the qualifying edge; i_addr is f_pc with no bypass.
// Backpressure: en=0 holds the PC and parks a branch redirect until fetch resumes; req overrides.
module f_pc_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
    parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
    parameter logic [31:0] IMEM_LIMIT = 32'h0000_6FFC,
    parameter logic [4:0]  EXC_ADEL   = 5'd4
) (
    input  logic   clk,
    input  logic   reset,
    f_pc_if.master pc_bus
);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } pend_state_t;

    pend_state_t state_q, state_d;
    logic [31:0] f_pc_q, f_pc_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic        fetch_acc;
    logic        addr_bad;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            f_pc_q      <= RESET_PC;
            pend_tgt_q  <= 32'h0;
            fetch_cnt_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            f_pc_q      <= f_pc_d;
            pend_tgt_q  <= pend_tgt_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    // Priority order: exception entry, stall, eret, live redirect, parked redirect, sequential.
    always_comb begin
        state_d    = state_q;
        f_pc_d     = f_pc_q;
        pend_tgt_d = pend_tgt_q;
        if (pc_bus.req) begin
            f_pc_d  = EXC_VECTOR;
            state_d = IDLE;
        end else if (!pc_bus.en) begin
            if (pc_bus.d_br_taken) begin
                state_d    = PEND;
                pend_tgt_d = pc_bus.d_br_target;
            end
        end else if (pc_bus.eret) begin
            f_pc_d  = pc_bus.epc;
            state_d = IDLE;
        end else if (pc_bus.d_br_taken) begin
            f_pc_d  = pc_bus.d_br_target;
            state_d = IDLE;
        end else if (state_q == PEND) begin
            f_pc_d  = pend_tgt_q;
            state_d = IDLE;
        end else begin
            f_pc_d = f_pc_q + 32'd4;
        end
    end

    assign fetch_acc   = pc_bus.en & ~pc_bus.req;
    assign fetch_cnt_d = fetch_acc ? fetch_cnt_q + 32'd1 : fetch_cnt_q;

    // Bad fetches are only flagged here; sequencing carries on until CP0 raises req.
    assign addr_bad = (f_pc_q[1:0] != 2'b00) || (f_pc_q < IMEM_BASE) || (f_pc_q > IMEM_LIMIT);

    assign pc_bus.f_pc      = f_pc_q;
    assign pc_bus.i_addr    = f_pc_q;
    assign pc_bus.f_exccode = addr_bad ? EXC_ADEL : 5'd0;
    assign pc_bus.i_rd_en   = ~addr_bad;
    assign pc_bus.f_bd      = pc_bus.d_is_branch & ~pc_bus.req;
    assign pc_bus.fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_f_pc_unit.sv
// Scoreboard bench for f_pc_unit: a reference model pushes expected PC/count per edge,
// popped and compared after the edge; directed checks cover the listed scenarios.
module tb_f_pc_unit;
    logic clk;
    logic reset;
    f_pc_if bus ();

    f_pc_unit dut (
        .clk    (clk),
        .reset  (reset),
        .pc_bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_pc, m_pt, m_cnt;
    logic        m_pv;
    logic        m_known = 1'b0;
    logic [31:0] q_pc[$];
    logic [31:0] q_cnt[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %08h want %08h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] exp_exc(input logic [31:0] pc);
        return (pc[1:0] != 2'b00 || pc < 32'h3000 || pc > 32'h6FFC) ? 5'd4 : 5'd0;
    endfunction

    task automatic step(input logic rst, input logic e, input logic rq, input logic er,
                        input logic [31:0] ep, input logic isb, input logic tk,
                        input logic [31:0] tg);
        @(negedge clk);
        reset              = rst;
        bus.en             = e;
        bus.req            = rq;
        bus.eret           = er;
        bus.epc            = ep;
        bus.d_is_branch    = isb;
        bus.d_br_taken     = tk;
        bus.d_br_target    = tg;
        #1;
        if (m_known) begin
            check("comb_pc",   bus.f_pc, m_pc);
            check("comb_addr", bus.i_addr, m_pc);
            check("comb_exc",  {27'd0, bus.f_exccode}, {27'd0, exp_exc(m_pc)});
            check("comb_rden", {31'd0, bus.i_rd_en}, {31'd0, exp_exc(m_pc) == 5'd0});
            check("comb_bd",   {31'd0, bus.f_bd}, {31'd0, isb & ~rq});
        end
        if (rst) begin
            m_pc = 32'h3000; m_pv = 1'b0; m_pt = 32'h0; m_cnt = 32'h0;
        end else begin
            if (e && !rq) m_cnt = m_cnt + 32'd1;
            if (rq) begin
                m_pc = 32'h4180; m_pv = 1'b0;
            end else if (!e) begin
                if (tk) begin m_pv = 1'b1; m_pt = tg; end
            end else if (er) begin
                m_pc = ep; m_pv = 1'b0;
            end else if (tk) begin
                m_pc = tg; m_pv = 1'b0;
            end else if (m_pv) begin
                m_pc = m_pt; m_pv = 1'b0;
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end
        q_pc.push_back(m_pc);
        q_cnt.push_back(m_cnt);
        @(posedge clk);
        #1;
        if (rst) m_known = 1'b1;
        if (q_pc.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            check("sb_pc",  bus.f_pc, q_pc.pop_front());
            check("sb_cnt", bus.fetch_cnt, q_cnt.pop_front());
        end
    endtask

    task automatic run(input logic e);
        step(1'b0, e, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic do_eret(input logic [31:0] ep);
        step(1'b0, 1'b1, 1'b0, 1'b1, ep, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] cnt_before;
        reset = 1'b1;
        bus.en = 1'b0; bus.req = 1'b0; bus.eret = 1'b0; bus.epc = 32'h0;
        bus.d_is_branch = 1'b0; bus.d_br_taken = 1'b0; bus.d_br_target = 32'h0;

        // Reset state and sequential fetch
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("rst_pc",   bus.f_pc, 32'h3000);
        check("rst_cnt",  bus.fetch_cnt, 32'h0);
        check("rst_exc",  {27'd0, bus.f_exccode}, 32'h0);
        check("rst_rden", {31'd0, bus.i_rd_en}, 32'h1);
        repeat (3) run(1'b1);
        check("t1_pc",  bus.f_pc, 32'h300C);
        check("t1_cnt", bus.fetch_cnt, 32'd3);
        run(1'b1);

        // Redirect parked during a stall
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h3100);
        check("t2_hold", bus.f_pc, 32'h3010);
        run(1'b0);
        check("t2_hold2", bus.f_pc, 32'h3010);
        run(1'b1);
        check("t2_tgt", bus.f_pc, 32'h3100);
        run(1'b1);
        check("t2_seq", bus.f_pc, 32'h3104);

        // Exception entry during stall; req with eret
        do_eret(32'h3020);
        cnt_before = bus.fetch_cnt;
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("t3_vec", bus.f_pc, 32'h4180);
        check("t3_cnt", bus.fetch_cnt, cnt_before);
        do_eret(32'h3000);
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'h3044, 1'b1, 1'b1, 32'h3300);
        check("t3_req_eret", bus.f_pc, 32'h4180);

        // Address check boundaries
        do_eret(32'h3002);
        check("t4_mis_exc",  {27'd0, bus.f_exccode}, 32'd4);
        check("t4_mis_rden", {31'd0, bus.i_rd_en}, 32'd0);
        run(1'b1);
        check("t4_mis_seq", bus.f_pc, 32'h3006);
        do_eret(32'h7000);
        check("t4_hi_exc", {27'd0, bus.f_exccode}, 32'd4);
        do_eret(32'h6FFC);
        check("t4_lim_exc", {27'd0, bus.f_exccode}, 32'd0);
        do_eret(32'h2FFC);
        check("t4_lo_exc", {27'd0, bus.f_exccode}, 32'd4);
        do_eret(32'h3040);
        check("t4_ok_exc", {27'd0, bus.f_exccode}, 32'd0);

        // Delay slot and same-cycle redirect
        do_eret(32'h3030);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h3200);
        check("t5_tgt", bus.f_pc, 32'h3200);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);

        // eret beats a live redirect and drops a parked one
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h3500);
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h3040, 1'b0, 1'b1, 32'h3600);
        check("eret_br", bus.f_pc, 32'h3040);
        run(1'b1);
        check("eret_drop", bus.f_pc, 32'h3044);

        // Newer parked redirect wins; req clears a parked redirect
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h3300);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h3400);
        run(1'b1);
        check("pend_new", bus.f_pc, 32'h3400);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h3300);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        run(1'b1);
        check("req_pend", bus.f_pc, 32'h4184);

        // Reset discards a parked redirect
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h3500);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        check("t6_rst", bus.f_pc, 32'h3000);
        run(1'b1);
        check("t6_seq", bus.f_pc, 32'h3004);

        // PC wraps modulo 2^32
        do_eret(32'hFFFF_FFFC);
        run(1'b1);
        check("wrap", bus.f_pc, 32'h0);

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            logic [31:0] ep, tg;
            ep = {18'd0, 14'($urandom_range(32'h3000, 32'h7004))};
            tg = {18'd0, 14'($urandom_range(32'h3000, 32'h7004))};
            if ($urandom_range(0, 3) != 0) begin
                ep[1:0] = 2'b00;
                tg[1:0] = 2'b00;
            end
            step($urandom_range(0, 60) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 12) == 0, $urandom_range(0, 8) == 0, ep,
                 1'($urandom_range(0, 1)), $urandom_range(0, 4) == 0, tg);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
